// File: rtl/joy_input_conditioner.sv
// Joystick-select and switch-bank input front end: 2-flop synchronisers,
// per-channel counter debounce, edge pulses and select auto-repeat.
module joy_input_conditioner #(
  parameter int N_SW          = 8,
  parameter int DB_CYCLES     = 50000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            joy_select_raw,
  input  logic [N_SW-1:0] switch_raw,
  output logic            joy_select,
  output logic            joy_press,
  output logic            joy_release,
  output logic [N_SW-1:0] switch,
  output logic [N_SW-1:0] switch_changed
);

  localparam int NCH = N_SW + 1;
  localparam int SEL = N_SW;
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  localparam int MAX_R = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW    = (MAX_R > 1) ? $clog2(MAX_R) : 1;
  localparam logic [HW-1:0] DELAY_LAST  = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
  localparam logic REPEAT_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] stable_q, stable_d;
  logic [NCH-1:0] flip;
  logic [DBW-1:0] db_cnt_q [NCH];
  logic [DBW-1:0] db_cnt_d [NCH];
  logic [N_SW-1:0] changed_q, changed_d;

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           sel_rise, sel_fall, delay_hit, period_hit;

  assign raw_all = {joy_select_raw, switch_raw};
  assign sync1_d = raw_all;
  assign sync2_d = sync1_q;

  // Debounce: any cycle of agreement clears the count; the flip happens on
  // the edge that would take the count to DB_CYCLES, so it never wraps.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      db_cnt_d[i] = '0;
      stable_d[i] = stable_q[i];
      flip[i]     = 1'b0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          flip[i]     = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign changed_d  = flip[N_SW-1:0];
  assign sel_rise   = flip[SEL] & ~stable_q[SEL];
  assign sel_fall   = flip[SEL] &  stable_q[SEL];
  assign delay_hit  = (hold_cnt_q == DELAY_LAST);
  assign period_hit = (hold_cnt_q == PERIOD_LAST);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_rise) begin
          state_d    = HELD;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        if (sel_fall) begin
          state_d = IDLE;
        end else if (REPEAT_EN) begin
          if (delay_hit) begin
            state_d    = REPEAT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (sel_fall) begin
          state_d = IDLE;
        end else if (period_hit) begin
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fall suppresses any repeat press due on the same edge.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: press_d = sel_rise;
      HELD: begin
        release_d = sel_fall;
        press_d   = !sel_fall && REPEAT_EN && delay_hit;
      end
      REPEAT: begin
        release_d = sel_fall;
        press_d   = !sel_fall && period_hit;
      end
      default: begin
        press_d   = 1'b0;
        release_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      changed_q  <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      changed_q  <= changed_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int i = 0; i < NCH; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign joy_select     = stable_q[SEL];
  assign switch         = stable_q[N_SW-1:0];
  assign switch_changed = changed_q;
  assign joy_press      = press_q;
  assign joy_release    = release_q;

endmodule
